// File: rtl/repetition_codec_pkg.sv
// Shared constants for the repetition codec: mode encoding and vote classes.
package repetition_codec_pkg;

    localparam logic MODE_ENCODE = 1'b0;
    localparam logic MODE_DECODE = 1'b1;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        CORRECTED = 2'd1,
        TIE       = 2'd2
    } vote_class_e;

endpackage

// File: rtl/repetition_vote_group.sv
// Combinational majority voter for one group of REPETITION_FACTOR copies.
// An exact half/half split (even factors only) is reported as a tie and
// resolves to 0.
module repetition_vote_group
    import repetition_codec_pkg::*;
#(
    parameter int REPETITION_FACTOR = 3
) (
    input  logic [REPETITION_FACTOR-1:0] grp,
    output logic                         value,
    output logic                         err,
    output logic                         tie
);

    localparam int CNT_W = $clog2(REPETITION_FACTOR + 1);
    localparam logic [CNT_W-1:0] ALL_ONES = CNT_W'(REPETITION_FACTOR);
    localparam logic [CNT_W:0]   FACTOR   = (CNT_W + 1)'(REPETITION_FACTOR);

    logic [CNT_W-1:0] ones;
    logic [CNT_W:0]   twice;
    vote_class_e      cls;

    // Count the ones in the group and compare twice that count with the factor.
    always_comb begin
        ones = '0;
        for (int k = 0; k < REPETITION_FACTOR; k++) begin
            ones = ones + CNT_W'(grp[k]);
        end
        twice = {ones, 1'b0};
        cls   = CORRECTED;
        value = 1'b0;
        if (ones == '0) begin
            cls = CLEAN;
        end else if (ones == ALL_ONES) begin
            cls   = CLEAN;
            value = 1'b1;
        end else if (twice > FACTOR) begin
            value = 1'b1;
        end else if (twice == FACTOR) begin
            cls = TIE;
        end
    end

    assign err = (cls != CLEAN);
    assign tie = (cls == TIE);

endmodule

// File: rtl/repetition_codec_stream.sv
// Streaming repetition-code encoder/decoder. Two-stage pipeline with
// valid/ready on both sides: stage 1 holds the raw word, stage 2 holds the
// classified result. Saturating statistics count corrected and tied words.
module repetition_codec_stream
    import repetition_codec_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int REPETITION_FACTOR = 3,
    parameter int CNT_WIDTH         = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic                                    in_mode,
    input  logic [DATA_WIDTH*REPETITION_FACTOR-1:0] in_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_WIDTH*REPETITION_FACTOR-1:0] out_codeword,
    output logic [DATA_WIDTH-1:0]                   out_data,
    output logic [DATA_WIDTH-1:0]                   out_err_bits,
    output logic                                    out_corrected,
    output logic                                    out_uncorrectable,
    input  logic                                    stats_clear,
    output logic [CNT_WIDTH-1:0]                    corr_count,
    output logic [CNT_WIDTH-1:0]                    uncorr_count
);

    localparam int R  = REPETITION_FACTOR;
    localparam int CW = DATA_WIDTH * REPETITION_FACTOR;

    logic                  vld_p1;
    logic                  mode_p1;
    logic [CW-1:0]         data_p1;
    logic                  vld_p2;
    logic [CW-1:0]         cw_p2;
    logic [DATA_WIDTH-1:0] data_p2;
    logic [DATA_WIDTH-1:0] err_p2;
    logic                  corr_p2;
    logic                  unc_p2;
    logic [CNT_WIDTH-1:0]  corr_acc;
    logic [CNT_WIDTH-1:0]  unc_acc;

    logic                  s1_advance;
    logic                  s2_advance;
    logic [DATA_WIDTH-1:0] vote_value;
    logic [DATA_WIDTH-1:0] vote_err;
    logic [DATA_WIDTH-1:0] vote_tie;
    logic [CW-1:0]         enc_cw;
    logic [CW-1:0]         res_cw;
    logic [DATA_WIDTH-1:0] res_data;
    logic [DATA_WIDTH-1:0] res_err;
    logic                  res_corr;
    logic                  res_unc;
    logic                  classify_dec;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) return v;
        return v + CNT_WIDTH'(1);
    endfunction

    assign s2_advance   = !vld_p2 || out_ready;
    assign s1_advance   = !vld_p1 || s2_advance;
    assign in_ready     = s1_advance && !rst;
    assign classify_dec = vld_p1 && s2_advance && (mode_p1 == MODE_DECODE);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_vote
        repetition_vote_group #(
            .REPETITION_FACTOR(R)
        ) u_vote (
            .grp  (data_p1[i*R +: R]),
            .value(vote_value[i]),
            .err  (vote_err[i]),
            .tie  (vote_tie[i])
        );
    end

    // Form the stage-1 result; the unused half of each result is forced to 0.
    always_comb begin
        enc_cw   = '0;
        res_cw   = '0;
        res_data = '0;
        res_err  = '0;
        res_corr = 1'b0;
        res_unc  = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            enc_cw[i*R +: R] = {R{data_p1[i]}};
        end
        if (mode_p1 == MODE_DECODE) begin
            res_data = vote_value;
            res_err  = vote_err;
            res_unc  = |vote_tie;
            res_corr = (|(vote_err & ~vote_tie)) && !res_unc;
        end else begin
            res_cw = enc_cw;
        end
    end

    // Stage 1 occupancy: a slot fills on accept and empties when it moves on.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (s1_advance) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage 1 payload: raw word and mode, captured on accept.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_p1 <= in_data;
            mode_p1 <= in_mode;
        end
    end

    // Stage 2 occupancy: follows stage 1 whenever the output slot can take it.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else if (s2_advance) begin
            vld_p2 <= vld_p1;
        end
    end

    // Stage 2 payload: classified result, frozen while the consumer stalls.
    always_ff @(posedge clk) begin
        if (s2_advance && vld_p1) begin
            cw_p2   <= res_cw;
            data_p2 <= res_data;
            err_p2  <= res_err;
            corr_p2 <= res_corr;
            unc_p2  <= res_unc;
        end
    end

    // Statistics: bump on decode classification; a clear wins over a bump.
    always_ff @(posedge clk) begin
        if (rst || stats_clear) begin
            corr_acc <= '0;
            unc_acc  <= '0;
        end else if (classify_dec) begin
            if (res_corr) corr_acc <= sat_inc(corr_acc);
            if (res_unc)  unc_acc  <= sat_inc(unc_acc);
        end
    end

    // Outputs read as zero whenever no result is presented or reset is held.
    assign out_valid         = vld_p2 && !rst;
    assign out_codeword      = out_valid ? cw_p2   : '0;
    assign out_data          = out_valid ? data_p2 : '0;
    assign out_err_bits      = out_valid ? err_p2  : '0;
    assign out_corrected     = out_valid && corr_p2;
    assign out_uncorrectable = out_valid && unc_p2;
    assign corr_count        = rst ? '0 : corr_acc;
    assign uncorr_count      = rst ? '0 : unc_acc;

endmodule
